// File: rtl/alien_shot_controller.sv
// Alien return fire: picks a pseudo-random armed alien, spawns one bullet under it,
// steps the bullet down once per frame and reports a player hit or off-screen retire.
module alien_shot_controller #(
    parameter int          NUM_ROWS      = 3,
    parameter int          NUM_COLS      = 5,
    parameter int          FIRE_COOLDOWN = 60,
    parameter int          BULLET_SPEED  = 4,
    parameter int          BULLET_W      = 2,
    parameter int          BULLET_H      = 8,
    parameter int          ALIEN_W       = 32,
    parameter int          ALIEN_H       = 16,
    parameter int          PLAYER_W      = 32,
    parameter int          PLAYER_H      = 16,
    parameter int          SCREEN_BOTTOM = 480,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frame_tick,
    input  logic                              enable,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0] armed_matrix,
    input  logic [15:0]                       alien_positions_x [NUM_ROWS][NUM_COLS],
    input  logic [15:0]                       alien_positions_y [NUM_ROWS][NUM_COLS],
    input  logic [9:0]                        player_x,
    input  logic [9:0]                        player_y,
    input  logic [9:0]                        scan_x,
    input  logic [9:0]                        scan_y,
    output logic                              bullet_active,
    output logic [9:0]                        bullet_x,
    output logic [9:0]                        bullet_y,
    output logic                              bullet_pixel,
    output logic                              shot_fired,
    output logic                              player_hit
);

    localparam int CD_RELOAD = (FIRE_COOLDOWN < 1) ? 1 : FIRE_COOLDOWN;
    localparam int CD_W      = $clog2(CD_RELOAD + 1);
    localparam int COL_W     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    localparam logic [CD_W-1:0]  CD_INIT   = CD_W'(CD_RELOAD);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(NUM_COLS - 1);
    localparam logic [15:0]      SPAWN_DX  = 16'(ALIEN_W / 2 - BULLET_W / 2);
    localparam logic [15:0]      SPAWN_DY  = 16'(ALIEN_H);
    localparam logic [15:0]      LFSR_MASK = 16'hB400;
    localparam logic [9:0]       SPD10     = 10'(BULLET_SPEED);
    localparam logic [10:0]      SPD11     = 11'(BULLET_SPEED);
    localparam logic [10:0]      BW11      = 11'(BULLET_W);
    localparam logic [10:0]      BH11      = 11'(BULLET_H);
    localparam logic [10:0]      PW11      = 11'(PLAYER_W);
    localparam logic [10:0]      PH11      = 11'(PLAYER_H);
    localparam logic [10:0]      BOTTOM11  = 11'(SCREEN_BOTTOM);

    typedef enum logic [1:0] {
        COOLDOWN,
        SELECT,
        FLIGHT
    } state_t;

    state_t           state_q;
    logic [CD_W-1:0]  cd_q;
    logic [COL_W-1:0] col_q;
    logic [COL_W-1:0] probes_q;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_d;
    logic             active_q;
    logic             shot_q;
    logic             hit_q;
    logic             pixel_q;
    logic             pixel_d;
    logic [9:0]       bx_q;
    logic [9:0]       by_q;

    logic             col_armed;
    logic [ROW_W-1:0] shooter;
    logic [COL_W-1:0] col_start;
    logic [COL_W-1:0] col_next;
    logic [15:0]      sum_x;
    logic [15:0]      sum_y;
    logic [9:0]       spawn_x;
    logic [9:0]       spawn_y;
    logic [10:0]      bx11;
    logic [10:0]      by11;
    logic [10:0]      px11;
    logic [10:0]      py11;
    logic [10:0]      sx11;
    logic [10:0]      sy11;
    logic             overlap;
    logic             off_screen;
    logic             unused_spawn_bits;

    // Galois LFSR free-runs every clock so the shooter choice keeps drifting
    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Column probe: the bottom-most (highest index) armed row in the column shoots
    always_comb begin
        col_armed = 1'b0;
        shooter   = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (armed_matrix[r][col_q]) begin
                col_armed = 1'b1;
                shooter   = ROW_W'(r);
            end
        end
    end

    assign col_start = COL_W'({24'd0, lfsr_q[7:0]} % NUM_COLS);
    assign col_next  = (col_q == COL_LAST) ? '0 : col_q + 1'b1;

    assign sum_x             = alien_positions_x[shooter][col_q] + SPAWN_DX;
    assign sum_y             = alien_positions_y[shooter][col_q] + SPAWN_DY;
    assign spawn_x           = sum_x[9:0];
    assign spawn_y           = sum_y[9:0];
    assign unused_spawn_bits = ^{sum_x[15:10], sum_y[15:10]};

    // Box compares are widened to 11 bits so edge sums near 1023 cannot wrap
    assign bx11 = {1'b0, bx_q};
    assign by11 = {1'b0, by_q};
    assign px11 = {1'b0, player_x};
    assign py11 = {1'b0, player_y};
    assign sx11 = {1'b0, scan_x};
    assign sy11 = {1'b0, scan_y};

    assign overlap    = (bx11 < px11 + PW11) && (bx11 + BW11 > px11) &&
                        (by11 < py11 + PH11) && (by11 + BH11 > py11);
    assign off_screen = (by11 + SPD11) >= BOTTOM11;

    assign pixel_d = active_q &&
                     (sx11 >= bx11) && (sx11 < bx11 + BW11) &&
                     (sy11 >= by11) && (sy11 < by11 + BH11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q <= 1'b0;
        end else begin
            pixel_q <= pixel_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COOLDOWN;
            cd_q     <= CD_INIT;
            col_q    <= '0;
            probes_q <= '0;
            active_q <= 1'b0;
            bx_q     <= '0;
            by_q     <= '0;
            shot_q   <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            shot_q <= 1'b0;
            hit_q  <= 1'b0;
            if (enable) begin
                case (state_q)
                    COOLDOWN: begin
                        if (frame_tick) begin
                            if (cd_q <= CD_W'(1)) begin
                                cd_q     <= '0;
                                col_q    <= col_start;
                                probes_q <= '0;
                                state_q  <= SELECT;
                            end else begin
                                cd_q <= cd_q - 1'b1;
                            end
                        end
                    end
                    SELECT: begin
                        if (col_armed) begin
                            bx_q     <= spawn_x;
                            by_q     <= spawn_y;
                            active_q <= 1'b1;
                            shot_q   <= 1'b1;
                            state_q  <= FLIGHT;
                        end else if (probes_q == COL_LAST) begin
                            cd_q    <= CD_INIT;
                            state_q <= COOLDOWN;
                        end else begin
                            col_q    <= col_next;
                            probes_q <= probes_q + 1'b1;
                        end
                    end
                    FLIGHT: begin
                        if (frame_tick) begin
                            if (overlap) begin
                                hit_q    <= 1'b1;
                                active_q <= 1'b0;
                                cd_q     <= CD_INIT;
                                state_q  <= COOLDOWN;
                            end else if (off_screen) begin
                                active_q <= 1'b0;
                                cd_q     <= CD_INIT;
                                state_q  <= COOLDOWN;
                            end else begin
                                by_q <= by_q + SPD10;
                            end
                        end
                    end
                    default: begin
                        state_q <= COOLDOWN;
                    end
                endcase
            end
        end
    end

    assign bullet_active = active_q;
    assign bullet_x      = bx_q;
    assign bullet_y      = by_q;
    assign bullet_pixel  = pixel_q;
    assign shot_fired    = shot_q;
    assign player_hit    = hit_q;

endmodule

// File: tb/tb_alien_shot_controller.sv
// Directed plus randomized bench for alien_shot_controller against a behavioural model
// of shooter choice, spawn position, flight, hit and retirement.
module tb_alien_shot_controller;

    localparam int NR = 3;
    localparam int NC = 5;
    localparam int CD = 60;

    logic                  clk        = 1'b0;
    logic                  rst_n      = 1'b0;
    logic                  frame_tick = 1'b0;
    logic                  enable     = 1'b1;
    logic [NR-1:0][NC-1:0] armed      = '0;
    logic [15:0]           pos_x [NR][NC];
    logic [15:0]           pos_y [NR][NC];
    logic [9:0]            player_x   = '0;
    logic [9:0]            player_y   = '0;
    logic [9:0]            scan_x     = '0;
    logic [9:0]            scan_y     = '0;
    logic                  bullet_active;
    logic [9:0]            bullet_x;
    logic [9:0]            bullet_y;
    logic                  bullet_pixel;
    logic                  shot_fired;
    logic                  player_hit;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [15:0] m_lfsr;
    logic [15:0] lfsr_at_tick;

    always #5 clk = ~clk;

    alien_shot_controller dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .frame_tick        (frame_tick),
        .enable            (enable),
        .armed_matrix      (armed),
        .alien_positions_x (pos_x),
        .alien_positions_y (pos_y),
        .player_x          (player_x),
        .player_y          (player_y),
        .scan_x            (scan_x),
        .scan_y            (scan_y),
        .bullet_active     (bullet_active),
        .bullet_x          (bullet_x),
        .bullet_y          (bullet_y),
        .bullet_pixel      (bullet_pixel),
        .shot_fired        (shot_fired),
        .player_hit        (player_hit)
    );

    // Reference pseudo-random source: 16-bit Galois LFSR, mask B400, steps every clock
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        lfsr_at_tick = m_lfsr;
        frame_tick   = 1'b1;
        @(negedge clk);
        frame_tick   = 1'b0;
    endtask

    function automatic bit overlap(int bx, int by, int px, int py);
        return (bx < px + 32) && (bx + 2 > px) && (by < py + 16) && (by + 8 > py);
    endfunction

    function automatic bit in_box(int sx, int sy, int bx, int by);
        return (sx >= bx) && (sx < bx + 2) && (sy >= by) && (sy < by + 8);
    endfunction

    // Walk columns from the LFSR-chosen start; first armed column wins, bottom row shoots
    function automatic void predict(input logic [15:0] lf, output int lat, output int row,
                                    output int col);
        int c0;
        int c;
        c0  = int'(lf[7:0]) % NC;
        lat = 0;
        row = -1;
        col = -1;
        for (int k = 0; k < NC; k++) begin
            c = (c0 + k) % NC;
            for (int r = 0; r < NR; r++) if (armed[r][c]) row = r;
            if (row >= 0) begin
                lat = k + 1;
                col = c;
                return;
            end
        end
    endfunction

    task automatic cooldown_and_shot(input string tag, output int lat_exp, output int ebx,
                                     output int eby);
        int early;
        int lat_obs;
        int row;
        int col;
        early = 0;
        ebx   = 0;
        eby   = 0;
        for (int i = 0; i < CD - 1; i++) begin
            tick();
            if (shot_fired) early++;
        end
        chk({tag, "_no_early_shot"}, early, 0);
        tick();
        predict(lfsr_at_tick, lat_exp, row, col);
        lat_obs = 0;
        for (int n = 1; n <= NC + 3; n++) begin
            @(negedge clk);
            if (shot_fired) begin
                lat_obs = n;
                break;
            end
        end
        chk({tag, "_shot_latency"}, lat_obs, lat_exp);
        if (lat_exp > 0) begin
            ebx = (int'(pos_x[row][col]) + 15) % 1024;
            eby = (int'(pos_y[row][col]) + 16) % 1024;
            chk({tag, "_active_on_spawn"}, int'(bullet_active), 1);
            chk({tag, "_spawn_x"}, int'(bullet_x), ebx);
            chk({tag, "_spawn_y"}, int'(bullet_y), eby);
        end
    endtask

    task automatic fly(input string tag, input int bx, input int by0, input bit rand_en,
                       output int ev_tick, output bit hit);
        int by;
        int en_ticks;
        bit done;
        bit en;
        by       = by0;
        en_ticks = 0;
        done     = 1'b0;
        ev_tick  = 0;
        hit      = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            en     = !(rand_en && ($urandom_range(0, 5) == 0));
            enable = en;
            tick();
            if (!en) begin
                chk({tag, "_frozen_y"}, int'(bullet_y), by);
                continue;
            end
            en_ticks++;
            if (overlap(bx, by, int'(player_x), int'(player_y))) begin
                done = 1'b1;
                hit  = 1'b1;
                chk({tag, "_hit_pulse"}, int'(player_hit), 1);
                chk({tag, "_active_after_hit"}, int'(bullet_active), 0);
            end else if (by + 4 >= 480) begin
                done = 1'b1;
                chk({tag, "_no_hit_on_retire"}, int'(player_hit), 0);
                chk({tag, "_active_after_retire"}, int'(bullet_active), 0);
            end else begin
                by += 4;
                chk({tag, "_flight_y"}, int'(bullet_y), by);
                chk({tag, "_flight_state"}, int'({bullet_active, player_hit}), 2);
            end
            if (done) ev_tick = en_ticks;
        end
        enable = 1'b1;
        chk({tag, "_event_within_bound"}, int'(done), 1);
        @(negedge clk);
        chk({tag, "_hit_is_pulse"}, int'(player_hit), 0);
        chk({tag, "_x_held"}, int'(bullet_x), bx);
        chk({tag, "_y_held"}, int'(bullet_y), by);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: observed no end expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int ebx;
        int eby;
        int ev;
        bit hit;
        int cnt;
        int psx;
        int psy;
        int nx;
        int ny;
        int sx_tab [8] = '{243, 244, 243, 244, 245, 242, 243, 243};
        int sy_tab [8] = '{130, 130, 137, 137, 130, 130, 129, 138};

        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                pos_x[r][c] = 16'(40 * c + 100 * r);
                pos_y[r][c] = 16'(20 * r + 50);
            end

        // Power-on reset
        repeat (3) @(negedge clk);
        chk("reset_active", int'(bullet_active), 0);
        chk("reset_x", int'(bullet_x), 0);
        chk("reset_y", int'(bullet_y), 0);
        chk("reset_pixel", int'(bullet_pixel), 0);
        chk("reset_shot", int'(shot_fired), 0);
        chk("reset_hit", int'(player_hit), 0);
        rst_n = 1'b1;

        // Single shooter at (228,114); player parked away from the bullet path
        armed       = '0;
        armed[2][2] = 1'b1;
        pos_x[2][2] = 16'd228;
        pos_y[2][2] = 16'd114;
        cooldown_and_shot("single", lat, ebx, eby);
        chk("single_bullet_x", int'(bullet_x), 243);
        chk("single_bullet_y", int'(bullet_y), 130);

        // Pixel: scan applied each clock, result must reflect the previous clock's scan
        @(negedge clk);
        scan_x = 10'(sx_tab[0]);
        scan_y = 10'(sy_tab[0]);
        psx    = sx_tab[0];
        psy    = sy_tab[0];
        for (int i = 1; i < 24; i++) begin
            @(negedge clk);
            nx     = (i < 8) ? sx_tab[i] : 240 + $urandom_range(0, 7);
            ny     = (i < 8) ? sy_tab[i] : 126 + $urandom_range(0, 15);
            scan_x = 10'(nx);
            scan_y = 10'(ny);
            #1;
            chk("pixel_lag1", int'(bullet_pixel), int'(in_box(psx, psy, 243, 130)));
            psx = nx;
            psy = ny;
        end

        for (int i = 0; i < 3; i++) tick();
        chk("single_y_after_3", int'(bullet_y), 142);

        enable = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("disabled_y_hold", int'(bullet_y), 142);
        chk("disabled_active_hold", int'(bullet_active), 1);
        enable = 1'b1;

        fly("offscreen", 243, 142, 1'b0, ev, hit);
        chk("offscreen_tick", ev + 3, 88);
        chk("offscreen_no_hit", int'(hit), 0);
        chk("offscreen_final_y", int'(bullet_y), 478);

        scan_x = 10'd243;
        scan_y = 10'd478;
        @(negedge clk);
        @(negedge clk);
        chk("pixel_inactive", int'(bullet_pixel), 0);

        // Nothing armed: five probes, then back to cooldown without a shot
        armed = '0;
        cnt   = 0;
        for (int i = 0; i < CD; i++) begin
            tick();
            if (shot_fired) cnt++;
        end
        for (int n = 0; n < NC; n++) begin
            @(negedge clk);
            if (shot_fired) cnt++;
        end
        armed = '1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (shot_fired) cnt++;
        end
        chk("noarm_no_shot_select_len", cnt, 0);

        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                pos_x[r][c] = 16'($urandom_range(0, 900));
                pos_y[r][c] = 16'($urandom_range(0, 300));
            end
        cooldown_and_shot("allarmed", lat, ebx, eby);
        chk("allarmed_latency_one", lat, 1);

        // Asynchronous reset mid-flight clears everything immediately
        @(negedge clk);
        scan_x = 10'(ebx);
        scan_y = 10'(eby);
        @(negedge clk);
        #1;
        chk("pixel_before_reset", int'(bullet_pixel), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_active", int'(bullet_active), 0);
        chk("midreset_x", int'(bullet_x), 0);
        chk("midreset_y", int'(bullet_y), 0);
        chk("midreset_pixel", int'(bullet_pixel), 0);
        chk("midreset_shot", int'(shot_fired), 0);
        chk("midreset_hit", int'(player_hit), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        scan_x = 10'd0;
        scan_y = 10'd0;

        // Hit: player at (236,400) under the single shooter
        armed       = '0;
        armed[2][2] = 1'b1;
        pos_x[2][2] = 16'd228;
        pos_y[2][2] = 16'd114;
        player_x    = 10'd236;
        player_y    = 10'd400;
        cooldown_and_shot("hit", lat, ebx, eby);
        fly("hit", 243, 130, 1'b0, ev, hit);
        chk("hit_tick", ev, 67);
        chk("hit_flag", int'(hit), 1);
        chk("hit_final_y", int'(bullet_y), 394);

        // Randomized rounds: sparse armed matrices, random geometry, enable dropouts
        for (int rnd = 0; rnd < 6; rnd++) begin
            for (int r = 0; r < NR; r++)
                for (int c = 0; c < NC; c++) begin
                    pos_x[r][c] = 16'($urandom_range(0, 1000));
                    pos_y[r][c] = 16'($urandom_range(0, 460));
                end
            armed = 15'($urandom) & 15'($urandom);
            if (rnd % 2 == 0) armed = armed & 15'($urandom);
            cnt      = $urandom_range(0, NC - 1);
            player_x = 10'((int'(pos_x[$urandom_range(0, NR - 1)][cnt]) + $urandom_range(0, 40)) % 1000);
            player_y = 10'($urandom_range(200, 470));
            cooldown_and_shot("random", lat, ebx, eby);
            if (lat > 0) fly("random", ebx, eby, 1'b1, ev, hit);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alien_shot_controller.md
# alien_shot_controller

Generates the alien return fire for the formation. It sits directly downstream of the alien formation and consumes that block's armed matrix and per-alien positions. It picks a pseudo-random armed alien, spawns one bullet beneath it, and moves the bullet down once per frame. It reports a hit when the bullet overlaps the player, and drives a registered bullet pixel for the VGA mixer.

## Interface
Parameters:
- NUM_ROWS, 3, formation rows
- NUM_COLS, 5, formation columns
- FIRE_COOLDOWN, 60, frame_ticks between bullet retirement/reset and next shot attempt (0 treated as 1)
- BULLET_SPEED, 4, pixels moved per frame_tick
- BULLET_W, 2 / BULLET_H, 8, bullet box size in pixels
- ALIEN_W, 32 / ALIEN_H, 16, alien box size (spawn offset)
- PLAYER_W, 32 / PLAYER_H, 16, player box size
- SCREEN_BOTTOM, 480, first y row off-screen
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-clk pulse per video frame
- enable  in  1  game running; low freezes all state
- armed_matrix  in  [NUM_ROWS][NUM_COLS]  alien may shoot
- alien_positions_x / alien_positions_y  in  16 each, [NUM_ROWS][NUM_COLS] unpacked  alien top-left
- player_x, player_y  in  10 each  player top-left
- scan_x, scan_y  in  10 each  current VGA scan position
- bullet_active  out  1  bullet in flight
- bullet_x, bullet_y  out  10 each  bullet top-left
- bullet_pixel  out  1  scan position inside bullet box
- shot_fired  out  1  one-clk pulse on spawn
- player_hit  out  1  one-clk pulse on hit

## Operation
- 16-bit Galois LFSR with mask 16'hB400.
  - Shifts every clk, independent of enable.
  - Reset value is LFSR_SEED.
- State machine: COOLDOWN, SELECT, FLIGHT. Reset state is COOLDOWN with cooldown count = FIRE_COOLDOWN.
- COOLDOWN:
  - Each frame_tick with enable high decrements the count.
  - The edge that takes the count to 0 moves the FSM to SELECT.
  - On that edge, probe column = LFSR[7:0] % NUM_COLS and probe count = 0.
- SELECT:
  - One column is probed per clk while enable is high.
  - A column is armed if any row bit is set in it. The highest set row is the shooter.
  - If the column is armed:
    - bullet_x = (pos_x + ALIEN_W/2 - BULLET_W/2)[9:0]
    - bullet_y = (pos_y + ALIEN_H)[9:0]
    - bullet_active <= 1, shot_fired pulses, FSM moves to FLIGHT.
  - If the column is not armed: column = (column + 1) wrapping at NUM_COLS, and the probe count increments.
  - After NUM_COLS unarmed probes: reload the cooldown count and return to COOLDOWN with no shot.
  - frame_tick is ignored in SELECT.
- FLIGHT, on each frame_tick with enable high, in priority order:
  1. Hit: the current bullet box overlaps the player box, i.e. bx < px+PLAYER_W, bx+BULLET_W > px, by < py+PLAYER_H, by+BULLET_H > py. Compute the compares in 11 bits so there is no wrap. On hit: player_hit pulses, bullet_active <= 0, reload the cooldown count, go to COOLDOWN.
  2. Off-screen: by + BULLET_SPEED >= SCREEN_BOTTOM (11-bit compare). Retire the bullet silently and go to COOLDOWN with the count reloaded.
  3. Otherwise: by <= by + BULLET_SPEED.
- enable low: the FSM, counters and bullet position hold. bullet_pixel is still driven.
- bullet_pixel is registered and high when all of these hold:
  - bullet_active is high
  - bullet_x <= scan_x < bullet_x + BULLET_W
  - bullet_y <= scan_y < bullet_y + BULLET_H
- bullet_x and bullet_y hold their last values after retirement.

## Timing
- Reset values: bullet_active, bullet_x, bullet_y, bullet_pixel, shot_fired and player_hit are all 0. The FSM is in COOLDOWN.
- Reset asserted mid-flight clears the bullet immediately (asynchronous). No player_hit pulse is produced.
- Shot latency: 1 to NUM_COLS clks after entering SELECT. shot_fired and bullet_active rise on the same edge.
- player_hit rises on the frame_tick edge that detects the overlap. bullet_active falls on that same edge.
- bullet_pixel lags scan_x/scan_y by exactly 1 clk.
- armed_matrix changing during SELECT: each probe uses the value sampled on that clk.

## Test plan
- Reset values: assert rst_n low mid-flight -> every output is 0 immediately; the first shot_fired comes no earlier than 60 frame_ticks after release.
- Single shooter: only armed[2][2] set, position (228,114) -> 60 frame_ticks later shot_fired within ≤5 clks, bullet at (243,130); after 3 further ticks bullet_y=142.
- No armed aliens: armed_matrix=0 -> SELECT lasts exactly 5 clks, then COOLDOWN; no shot_fired for 60 further ticks.
- Hit: same shooter, player at (236,400) -> player_hit on the 67th frame_tick after shot_fired (bullet_y=394); bullet_active falls on the same edge.
- Off-screen: same shooter, player at (0,0) -> on the 88th frame_tick (bullet_y=478), bullet_active falls with no player_hit.
- enable low for 10 ticks during FLIGHT -> bullet_y unchanged. Pixel check: with bullet at (243,130), scan (243..244, 130..137) gives bullet_pixel=1 one clk later; scan (245,130) gives 0.
